// File: rtl/wb_burst_master.sv
// Wishbone B3 master: single or incrementing-burst transfers with bounded retry and error abort.
// Optional WB_MASTER_TIMEOUT_EN adds a no-response timeout and the timeout_o port.
module wb_burst_master #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int BL_W      = 4,
    parameter int MAX_RETRY = 3,
    parameter int RETRY_DLY = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    output logic [aw-1:0]   wb_adr_o,
    output logic [dw-1:0]   wb_dat_o,
    output logic [dw/8-1:0] wb_sel_o,
    output logic            wb_we_o,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic [2:0]      wb_cti_o,
    output logic [1:0]      wb_bte_o,
    input  logic [dw-1:0]   wb_dat_i,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic            wb_rty_i,
    input  logic            start,
    input  logic [aw-1:0]   address,
    input  logic [dw/8-1:0] selection,
    input  logic            write,
    input  logic [BL_W-1:0] burst_len,
    input  logic [dw-1:0]   data_wr,
    output logic            data_wr_pop,
    output logic [dw-1:0]   data_rd,
    output logic            data_rd_valid,
    output logic            active,
    output logic            done,
    output logic            error,
`ifdef WB_MASTER_TIMEOUT_EN
    output logic            timeout_o,
`endif
    output logic [1:0]      state_dbg
);

    // Handshake: start is taken only in IDLE (active=0); data_wr is the head of the
    // caller's source and is consumed on the cycle data_wr_pop pulses.
    typedef enum logic [1:0] {IDLE, BUS, RTY_WAIT, FAIL} state_t;

    localparam int RW  = $clog2(MAX_RETRY + 1);
    localparam int DLW = $clog2(RETRY_DLY + 1);
    localparam logic [aw-1:0] STEP = aw'(dw / 8);
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    state_t          state_q, state_d;
    logic [BL_W-1:0] beats_left;
    logic [RW-1:0]   retry_cnt;
    logic [DLW-1:0]  dly_cnt;
    logic            launch, beat, last_beat, go_rty, go_fail, reissue;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          tmo;
`endif

    assign wb_bte_o  = 2'b00;
    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        beat      = 1'b0;
        last_beat = 1'b0;
        go_rty    = 1'b0;
        go_fail   = 1'b0;
        reissue   = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
        tmo       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    launch  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                // err outranks rty, which outranks ack; only a lone ack moves a beat
                if (wb_err_i) begin
                    go_fail = 1'b1;
                    state_d = FAIL;
                end else if (wb_rty_i) begin
                    if (retry_cnt == RW'(MAX_RETRY - 1)) begin
                        go_fail = 1'b1;
                        state_d = FAIL;
                    end else begin
                        go_rty  = 1'b1;
                        state_d = RTY_WAIT;
                    end
                end else if (wb_ack_i) begin
                    beat = 1'b1;
                    if (beats_left == '0) begin
                        last_beat = 1'b1;
                        state_d   = IDLE;
                    end
                end
`ifdef WB_MASTER_TIMEOUT_EN
                else if (to_cnt == TW'(TIMEOUT - 1)) begin
                    tmo     = 1'b1;
                    go_fail = 1'b1;
                    state_d = FAIL;
                end
`endif
            end
            RTY_WAIT: begin
                if (dly_cnt == DLW'(RETRY_DLY - 1)) begin
                    reissue = 1'b1;
                    state_d = BUS;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q       <= IDLE;
            wb_adr_o      <= '0;
            wb_dat_o      <= '0;
            wb_sel_o      <= '0;
            wb_we_o       <= 1'b0;
            wb_cyc_o      <= 1'b0;
            wb_stb_o      <= 1'b0;
            wb_cti_o      <= CTI_CLASSIC;
            data_wr_pop   <= 1'b0;
            data_rd       <= '0;
            data_rd_valid <= 1'b0;
            active        <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            beats_left    <= '0;
            retry_cnt     <= '0;
            dly_cnt       <= '0;
        end else begin
            state_q       <= state_d;
            data_wr_pop   <= 1'b0;
            data_rd_valid <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            if (state_q == RTY_WAIT) dly_cnt <= dly_cnt + 1'b1;
            if (launch) begin
                wb_adr_o    <= address;
                wb_sel_o    <= selection;
                wb_we_o     <= write;
                beats_left  <= burst_len;
                wb_dat_o    <= data_wr;
                data_wr_pop <= write;
                wb_cyc_o    <= 1'b1;
                wb_stb_o    <= 1'b1;
                active      <= 1'b1;
                retry_cnt   <= '0;
                wb_cti_o    <= (burst_len == '0) ? CTI_CLASSIC : CTI_INCR;
            end
            if (beat) begin
                wb_adr_o <= wb_adr_o + STEP;
                if (!wb_we_o) begin
                    data_rd       <= wb_dat_i;
                    data_rd_valid <= 1'b1;
                end
                if (last_beat) begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    active   <= 1'b0;
                    done     <= 1'b1;
                end else begin
                    beats_left <= beats_left - 1'b1;
                    wb_cti_o   <= (beats_left == BL_W'(1)) ? CTI_END : CTI_INCR;
                    if (wb_we_o) begin
                        wb_dat_o    <= data_wr;
                        data_wr_pop <= 1'b1;
                    end
                end
            end
            if (go_rty) begin
                wb_cyc_o  <= 1'b0;
                wb_stb_o  <= 1'b0;
                retry_cnt <= retry_cnt + 1'b1;
                dly_cnt   <= '0;
            end
            if (go_fail) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                active   <= 1'b0;
                done     <= 1'b1;
                error    <= 1'b1;
            end
            // Re-issue keeps address, cti and wb_dat_o of the beat that was retried
            if (reissue) begin
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
            end
        end
    end

`ifdef WB_MASTER_TIMEOUT_EN
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            to_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= tmo;
            if (state_q == BUS && !(wb_ack_i || wb_err_i || wb_rty_i))
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
        end
    end
`endif

endmodule
